// File: rtl/rams128_arbiter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rams128_arbiter_ctrl_pkg : shared constants for the 128-word RAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rams128_arbiter_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic is_last_word(input addr_t adr);
    return adr == addr_t'(DEPTH - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rams128_arbiter_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin grant; on a tie the side that did not win last
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import rams128_arbiter_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = enable_i & req_i[0] & (~req_i[1] | (last_i == REQ_B));
  assign gnt_o[1] = enable_i & req_i[1] & (~req_i[0] | (last_i == REQ_A));

endmodule

`default_nettype wire

// File: rtl/rams128_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// rams128_arbiter_ctrl : shares one 128 x WIDTH async-read RAM between two
// requesters, with a full-memory clear sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rams128_arbiter_ctrl
  import rams128_arbiter_ctrl_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] CLR_VALUE      = '0,
  parameter bit               CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_start_i,
  output logic              busy_o,

  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_adr_i,
  input  logic [WIDTH-1:0]  a_d_i,
  output logic              a_gnt_o,
  output logic [WIDTH-1:0]  a_q_o,
  output logic              a_qv_o,

  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_adr_i,
  input  logic [WIDTH-1:0]  b_d_i,
  output logic              b_gnt_o,
  output logic [WIDTH-1:0]  b_q_o,
  output logic              b_qv_o,

  output logic [ADDR_W-1:0] ram_adr_o,
  output logic              ram_we_o,
  output logic [WIDTH-1:0]  ram_i_o,
  input  logic [WIDTH-1:0]  ram_o_i
);

  localparam logic [0:0] RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  logic [0:0]  state_q, state_d;
  addr_t       cnt_q, cnt_d;
  logic        last_q, last_d;
  addr_t       adr_q;
  logic [WIDTH-1:0] a_q_q, b_q_q;
  logic        a_qv_q, b_qv_q;

  logic        in_clear;
  logic        serve_en;
  logic [1:0]  gnt;
  logic        a_rd, b_rd;

  assign in_clear = (state_q == ST_CLEAR);
  // Grants are suppressed while reset is held so all outputs sit at rest.
  assign serve_en = (state_q == ST_SERVE) & ~clr_start_i & ~rst_i;

  rr_arb2 u_arb (
    .req_i    ({b_req_i, a_req_i}),
    .last_i   (last_q),
    .enable_i (serve_en),
    .gnt_o    (gnt)
  );

  assign a_rd = gnt[0] & ~a_we_i;
  assign b_rd = gnt[1] & ~b_we_i;

  always_comb begin
    ram_adr_o = adr_q;
    ram_we_o  = 1'b0;
    ram_i_o   = '0;
    if (rst_i) begin
      ram_adr_o = '0;
    end else if (in_clear) begin
      ram_adr_o = cnt_q;
      ram_we_o  = 1'b1;
      ram_i_o   = CLR_VALUE;
    end else if (gnt[0]) begin
      ram_adr_o = a_adr_i;
      ram_we_o  = a_we_i;
      ram_i_o   = a_d_i;
    end else if (gnt[1]) begin
      ram_adr_o = b_adr_i;
      ram_we_o  = b_we_i;
      ram_i_o   = b_d_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (in_clear) begin
      if (clr_start_i) begin
        cnt_d = '0;
      end else if (is_last_word(cnt_q)) begin
        cnt_d   = '0;
        state_d = ST_SERVE;
      end else begin
        cnt_d = cnt_q + addr_t'(1);
      end
    end else if (clr_start_i) begin
      cnt_d   = '0;
      state_d = ST_CLEAR;
    end
    if (gnt[0]) begin
      last_d = REQ_A;
    end else if (gnt[1]) begin
      last_d = REQ_B;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      last_q  <= REQ_B;
      adr_q   <= '0;
      a_q_q   <= '0;
      b_q_q   <= '0;
      a_qv_q  <= 1'b0;
      b_qv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      adr_q   <= ram_adr_o;
      a_qv_q  <= a_rd;
      b_qv_q  <= b_rd;
      if (a_rd) begin
        a_q_q <= ram_o_i;
      end
      if (b_rd) begin
        b_q_q <= ram_o_i;
      end
    end
  end

  assign busy_o  = in_clear;
  assign a_gnt_o = gnt[0];
  assign b_gnt_o = gnt[1];
  assign a_q_o   = a_q_q;
  assign b_q_o   = b_q_q;
  assign a_qv_o  = a_qv_q;
  assign b_qv_o  = b_qv_q;

endmodule

`default_nettype wire
